// File: rtl/bus_generator_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and helpers for the bus generator/arbiter.
//               Packet destination ID width, broadcast ID, FSM state type,
//               and id_of() which extracts the destination byte from a packet.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int              ID_W         = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    // Widest packet id_of() accepts; callers zero-extend into this width.
    localparam int              PKT_MAX_W    = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // Destination ID is the top byte of the packet; msb is packet width - 1.
    function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input logic [7:0]           msb);
        return ID_W'(pkt >> (msb - 8'd7));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_generator_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_generator_arbiter_if
// Description : Bundle of per-driver FIFO signals shared by the arbiter.
//               pndng  - driver FIFO non-empty
//               D_pop  - driver FIFO head packet
//               pop    - consume head packet of driver i
//               push   - write D_push into receive FIFO of driver i
//               D_push - bus data, identical on every lane
//               master : arbiter side, slave : FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_generator_arbiter_if #(
    parameter int BITS    = 1,
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16
);
    logic [BITS-1:0][DRVRS-1:0]              pndng;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [BITS-1:0][DRVRS-1:0]              pop;
    logic [BITS-1:0][DRVRS-1:0]              push;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push
    );
endinterface
`default_nettype wire

// File: rtl/bus_generator_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the lowest-index
//               requester at or after ptr, wrapping modulo DRVRS.
//               req   - request vector
//               ptr   - index with highest priority this round
//               grant - one-hot grant
//               valid - any request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int DRVRS = 4,
    localparam int PTR_W = $clog2(DRVRS)
) (
    input  logic [DRVRS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [DRVRS-1:0] grant,
    output logic             valid
);

    // One extra bit so ptr + k never overflows before the modulo fold.
    logic [PTR_W:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < DRVRS; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(DRVRS)) begin
                idx = idx - (PTR_W+1)'(DRVRS);
            end
            if (!valid && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_generator_arbiter
// Description : Shared-bus generator with round-robin arbitration. Pops the
//               head packet of one pending driver, then pushes it to the
//               driver named by its destination ID, or to every driver but
//               the source for the broadcast ID. One packet per 3 cycles.
//               clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - per-driver FIFO signals (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_generator_arbiter
    import bus_pkg::*;
#(
    parameter int              BITS      = 1,
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_generator_arbiter_if.master bus
);

    localparam int              PTR_W  = $clog2(DRVRS);
    localparam logic [7:0]      ID_MSB = 8'(PCKG_SZ - 1);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic [PTR_W-1:0]     src_q,   src_d;
    logic [PCKG_SZ-1:0]   bus_q,   bus_d;
    logic [DRVRS-1:0]     pop_q,   pop_d;
    logic [DRVRS-1:0]     push_q,  push_d;
    logic [PCKG_SZ-1:0]   dpush_q, dpush_d;

    logic [DRVRS-1:0]     w_grant;
    logic                 w_valid;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [PCKG_SZ-1:0]   w_grant_data;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [ID_W-1:0]      w_id;
    logic [DRVRS-1:0]     w_push_dec;

    rr_arbiter #(
        .DRVRS (DRVRS)
    ) u_rr_arbiter (
        .req   (bus.pndng[0]),
        .ptr   (ptr_q),
        .grant (w_grant),
        .valid (w_valid)
    );

    // Grant is one-hot, so OR-reduction yields the index and the packet.
    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = w_grant_idx  | PTR_W'(i);
                w_grant_data = w_grant_data | bus.D_pop[0][i];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == PTR_W'(DRVRS - 1)) ? '0 : w_grant_idx + 1'b1;

    // Destination decode; IDs at or above DRVRS match no lane and are dropped.
    assign w_id = id_of(PKT_MAX_W'(bus_q), ID_MSB);

    always_comb begin
        w_push_dec = '0;
        for (int j = 0; j < DRVRS; j++) begin
            if (w_id == BROADCAST) begin
                w_push_dec[j] = (src_q != PTR_W'(j));
            end else begin
                w_push_dec[j] = (w_id == ID_W'(j));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        bus_d   = bus_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        case (state_q)
            IDLE: begin
                if (w_valid) begin
                    pop_d   = w_grant;
                    bus_d   = w_grant_data;
                    src_d   = w_grant_idx;
                    ptr_d   = w_next_ptr;
                    state_d = POP;
                end
            end
            POP: begin
                dpush_d = bus_q;
                push_d  = w_push_dec;
                state_d = PUSH;
            end
            PUSH: begin
                // Turnaround: source FIFO updates pndng before next arbitration.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            bus_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            bus_q   <= bus_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
        end
    end

    generate
        for (genvar b = 0; b < BITS; b++) begin : g_lane
            assign bus.pop[b]  = pop_q;
            assign bus.push[b] = push_q;
            for (genvar i = 0; i < DRVRS; i++) begin : g_drv
                assign bus.D_push[b][i] = dpush_q;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bus_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_generator_arbiter
// Description : Self-checking bench for bus_generator_arbiter. Directed and
//               random transactions are compared against a transaction-level
//               reference model (round-robin winner, destination decode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_generator_arbiter;

    localparam int BITS    = 1;
    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_generator_arbiter_if #(.BITS(BITS), .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ)) bif ();

    bus_generator_arbiter #(
        .BITS      (BITS),
        .DRVRS     (DRVRS),
        .PCKG_SZ   (PCKG_SZ),
        .BROADCAST (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    int                 n_checks = 0;
    int                 n_fails  = 0;
    int                 rr_ptr   = 0;
    logic [PCKG_SZ-1:0] pkt [DRVRS];
    logic [DRVRS-1:0]   pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        bif.pndng[0] = pend;
        for (int i = 0; i < DRVRS; i++) bif.D_pop[0][i] = pkt[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(input logic [DRVRS-1:0] p, input int ptr);
        for (int k = 0; k < DRVRS; k++) begin
            if (p[(ptr + k) % DRVRS]) return (ptr + k) % DRVRS;
        end
        return -1;
    endfunction

    function automatic logic [DRVRS-1:0] model_push(input logic [PCKG_SZ-1:0] d, input int src);
        int id;
        id = int'(d[PCKG_SZ-1 -: 8]);
        if (id == 255)      return DRVRS'(((1 << DRVRS) - 1) ^ (1 << src));
        else if (id < DRVRS) return DRVRS'(1 << id);
        else                 return '0;
    endfunction

    function automatic logic [63:0] lanes(input logic [PCKG_SZ-1:0] d);
        return {DRVRS{d}};
    endfunction

    // Drives the current pend/pkt, then follows one arbitration round.
    task automatic run_txn(input string tag, input bit drop_after_pop);
        int                 w;
        logic [PCKG_SZ-1:0] d;
        drive_inputs();
        w = model_winner(pend, rr_ptr);
        step();
        if (w < 0) begin
            check({tag, " idle pop"},  64'(bif.pop),  64'(0));
            check({tag, " idle push"}, 64'(bif.push), 64'(0));
            return;
        end
        d = pkt[w];
        check({tag, " pop"},       64'(bif.pop),  64'(1 << w));
        check({tag, " push@pop"},  64'(bif.push), 64'(0));
        rr_ptr = (w + 1) % DRVRS;
        if (drop_after_pop) begin
            // Late pndng drop and head change must not affect captured data.
            pend[w] = 1'b0;
            pkt[w]  = ~pkt[w];
            drive_inputs();
        end
        step();
        check({tag, " pop@push"},  64'(bif.pop),  64'(0));
        check({tag, " push"},      64'(bif.push), 64'(model_push(d, w)));
        check({tag, " D_push"},    64'(bif.D_push), lanes(d));
        step();
        check({tag, " push end"},  64'(bif.push), 64'(0));
        check({tag, " pop end"},   64'(bif.pop),  64'(0));
        check({tag, " D_push hold"}, 64'(bif.D_push), lanes(d));
    endtask

    initial begin
        int w;
        // Reset held with every driver pending.
        reset = 1'b0;
        pend  = 4'b1111;
        for (int i = 0; i < DRVRS; i++) pkt[i] = {8'h00, 8'(i)};
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            check("reset pop",    64'(bif.pop),    64'(0));
            check("reset push",   64'(bif.push),   64'(0));
            check("reset D_push", 64'(bif.D_push), 64'(0));
        end
        reset  = 1'b1;
        rr_ptr = 0;

        // Round-robin with all drivers continuously pending.
        for (int n = 0; n < 8; n++) run_txn("rr", 1'b0);

        // Directed destinations.
        pend = 4'b0010; pkt[1] = 16'h02AB; run_txn("unicast", 1'b1);
        pend = 4'b1000; pkt[3] = 16'hFF55; run_txn("broadcast", 1'b1);
        pend = 4'b0001; pkt[0] = 16'h0711; run_txn("invalid_id", 1'b1);
        pend = 4'b0000; run_txn("idle", 1'b0);
        run_txn("idle", 1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            pend = 4'($urandom_range(0, 15));
            for (int i = 0; i < DRVRS; i++) begin
                case ($urandom_range(0, 3))
                    0:       pkt[i] = {8'($urandom_range(0, DRVRS - 1)), 8'($urandom)};
                    1:       pkt[i] = {8'hFF, 8'($urandom)};
                    default: pkt[i] = 16'($urandom);
                endcase
            end
            run_txn("random", 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between pop and push.
        pend = 4'b0001; pkt[0] = 16'h0123;
        drive_inputs();
        w = model_winner(pend, rr_ptr);
        step();
        check("abort pop", 64'(bif.pop), 64'(1 << w));
        #2;
        reset = 1'b0;
        #1;
        check("abort async pop",    64'(bif.pop),    64'(0));
        check("abort async push",   64'(bif.push),   64'(0));
        check("abort async D_push", 64'(bif.D_push), 64'(0));
        for (int c = 0; c < 2; c++) begin
            step();
            check("abort held push", 64'(bif.push), 64'(0));
        end
        pend = 4'b0000;
        drive_inputs();
        reset  = 1'b1;
        rr_ptr = 0;
        step();
        check("abort no push", 64'(bif.push), 64'(0));
        step();
        check("abort no push", 64'(bif.push), 64'(0));

        // Pointer must restart at driver 0 after reset.
        pend = 4'b1111;
        for (int i = 0; i < DRVRS; i++) pkt[i] = {8'h00, 8'(i)};
        run_txn("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_generator_arbiter.md
Name:
bus_generator_arbiter

Overview:
- Shared-bus generator and round-robin arbiter connecting DRVRS driver FIFOs over one bus.
- Pops the head packet from a pending driver and routes it by destination ID, either to one driver or broadcast to all others.
- Sits between the per-driver FIFO interfaces (D_pop/pndng from each FIFO, D_push/push into each receive FIFO) in the bus-driver subsystem.

Parameters:
- bits, 1, number of buses; only 1 is supported, kept for port shape.
- drvrs, 4, number of drivers on the bus (2..255).
- pckg_sz, 16, packet width in bits (minimum 9).
- broadcast, 8'hFF, destination ID meaning "all drivers except the source".

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pndng  input  [bits-1:0][drvrs-1:0]  driver i FIFO is non-empty.
- D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head packet of driver i FIFO; valid while pndng[i] is high.
- pop  output  [bits-1:0][drvrs-1:0]  one-cycle pulse that consumes driver i's head packet.
- push  output  [bits-1:0][drvrs-1:0]  one-cycle pulse that writes D_push into driver i's receive FIFO.
- D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  bus data; every lane carries the same value.

Behaviour:
- Packet format: ID = D_pop[pckg_sz-1 -: 8] (destination); the remaining bits are payload and are passed unmodified.
- Reset (reset=0, asynchronous):
  - pop, push, D_push go to 0.
  - State machine goes to IDLE.
  - Round-robin pointer goes to 0; bus register and source register clear.
- All outputs are registered. FSM states: IDLE, POP, PUSH.
- IDLE:
  - If any pndng is set, grant the lowest index i at or after the pointer, modulo drvrs.
  - On that edge: pop[i] <= 1, bus_reg <= D_pop[i], src <= i, pointer <= (i+1) mod drvrs; go to POP.
  - If no pndng is set, stay in IDLE with all outputs 0.
- POP (pop pulse visible this cycle):
  - pop <= 0, D_push <= bus_reg on all lanes.
  - Set push bits by ID:
    - ID == broadcast: push[j]=1 for all j != src.
    - ID < drvrs: push[ID]=1; a self-addressed packet (ID == src) is delivered to src.
    - Any other ID: push stays 0 and the packet is dropped.
  - Go to PUSH.
- PUSH (push pulse visible this cycle):
  - push <= 0; D_push holds its value; go to IDLE.
  - This turnaround cycle lets the source FIFO update pndng before the next arbitration.
- Timing:
  - pop appears 1 cycle after the pndng sample.
  - push appears 2 cycles after the pndng sample.
  - Maximum throughput is one packet per 3 cycles.
- Fairness: a driver with pndng continuously high is served at least once every drvrs packets.
- Receive FIFO fullness is not monitored; downstream FIFOs must absorb pushes.
- Reset asserted mid-transfer aborts the transfer. The popped packet is lost, with no push issued.
- pndng dropping between sample and pop has no effect: the pop is still issued and the captured data is delivered.

Decomposition:
- Package bus_pkg: ID_W=8, BROADCAST_ID=8'hFF, state enum {IDLE, POP, PUSH}, function id_of(pkt).
- One sub-module, rr_arbiter: inputs req[drvrs-1:0] and pointer; outputs a one-hot grant and a valid flag; purely combinational.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pndng=4'b1111 -> pop=0, push=0, D_push=0 throughout. After release, the first pop is on driver 0.
- Unicast: pndng[1]=1, D_pop[1]=16'h02AB -> pop[1] pulses for 1 cycle, next cycle push=4'b0100 with D_push=16'h02AB on all lanes, then push=0.
- Broadcast: pndng[3]=1, D_pop[3]=16'hFF55 -> pop[3], then push=4'b0111 with D_push=16'hFF55.
- Round-robin: pndng=4'b1111 held, D_pop[i]={8'h00,i} -> pop order 0,1,2,3,0,… with one pop every 3 cycles.
- Invalid ID: D_pop[0]=16'h0711, pndng[0]=1 -> pop[0] pulses and no push follows.
- Async reset in POP state: drop reset between the pop and push cycles -> push never asserts; outputs are 0 immediately, before the next clock edge.
